// File: rtl/spi_cmd_ctrl_pkg.sv
// Shared definitions for the SPI command sequencer: command opcodes,
// sequencer state encoding, field widths and small address helpers.
package spi_cmd_pkg;

    localparam int FB_ADDR_W   = 14;
    localparam int CTRL_ADDR_W = 6;
    localparam int BURST_W     = 6;
    localparam int DATA_W      = 8;

    // Command byte bits [7:6]
    typedef enum logic [1:0] {
        OP_NOP      = 2'b00,
        OP_SET_ADDR = 2'b01,
        OP_CTRL_WR  = 2'b10,
        OP_BURST    = 2'b11
    } opcode_t;

    typedef enum logic [1:0] {
        S_IDLE    = 2'b00,
        S_ADDR_LO = 2'b01,
        S_CTRL    = 2'b10,
        S_DATA    = 2'b11
    } state_t;

    // Framebuffer address advance; wraps 0x3FFF -> 0x0000 by width.
    function automatic logic [FB_ADDR_W-1:0] fb_addr_inc(input logic [FB_ADDR_W-1:0] addr);
        return addr + {{(FB_ADDR_W-1){1'b0}}, 1'b1};
    endfunction

    function automatic opcode_t cmd_opcode(input logic [DATA_W-1:0] cmd);
        return opcode_t'(cmd[7:6]);
    endfunction

endpackage

// File: rtl/spi_cmd_ctrl_sync_edge.sv
// sync_edge: multi-flop synchronizer for a level crossing into clk,
// followed by a rising-edge detector producing a one-cycle pulse.
// Reusable for any slow level-signalled crossing into the clk domain.
module sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    output logic pulse
);

    // Fewer than two stages gives no metastability protection.
    localparam int STAGES = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

    logic [STAGES-1:0] sync_reg;
    logic              last_reg;

    // Shift the asynchronous level through the synchronizer chain and
    // remember the previous synchronized value for edge detection.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_reg <= '0;
            last_reg <= 1'b0;
        end else begin
            sync_reg <= {sync_reg[STAGES-2:0], async_in};
            last_reg <= sync_reg[STAGES-1];
        end
    end

    assign pulse = sync_reg[STAGES-1] & ~last_reg;

endmodule

// File: rtl/spi_cmd_ctrl.sv
// spi_cmd_ctrl: turns completed SPI bytes into framebuffer writes and
// video control register writes using a byte-counted command protocol.
// Optional feature macro: SPI_CMD_TIMEOUT_EN -- abandons a partial
// command after TIMEOUT_CYCLES clocks without a new byte.
module spi_cmd_ctrl
    import spi_cmd_pkg::*;
#(
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                   Clk,
    input  logic                   ResetN,
    input  logic                   DataRecv,
    input  logic [DATA_W-1:0]      DataIn,
    output logic [FB_ADDR_W-1:0]   MemAddr,
    output logic [DATA_W-1:0]      MemData,
    output logic                   MemWe,
    input  logic                   MemReady,
    output logic [CTRL_ADDR_W-1:0] CtrlAddr,
    output logic [DATA_W-1:0]      CtrlData,
    output logic                   CtrlWe,
    output logic                   Busy,
    output logic                   Overrun
);

    logic                   byte_stb;
    logic [DATA_W-1:0]      rx_byte;

    state_t                 state_reg;
    logic [FB_ADDR_W-1:0]   addr_reg;
    logic [BURST_W-1:0]     count_reg;     // remaining data bytes minus one
    logic [CTRL_ADDR_W-1:0] ctrl_idx_reg;

    logic [FB_ADDR_W-1:0]   mem_addr_reg;
    logic [DATA_W-1:0]      mem_data_reg;
    logic                   mem_we_reg;
    logic [CTRL_ADDR_W-1:0] ctrl_addr_reg;
    logic [DATA_W-1:0]      ctrl_data_reg;
    logic                   ctrl_we_reg;
    logic                   overrun_reg;

    logic                   mem_accept;
    logic                   mem_stall;
    logic [FB_ADDR_W-1:0]   addr_next;

    sync_edge #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_recv_sync (
        .clk      (Clk),
        .rst_n    (ResetN),
        .async_in (DataRecv),
        .pulse    (byte_stb)
    );

    // DataIn is held stable for the whole DataRecv high level, so it is
    // safe to sample directly on the synchronized strobe.
    assign rx_byte = DataIn;

    // Acceptance retires the pending write before a same-cycle byte is
    // considered, so only a still-stalled write causes an overrun.
    assign mem_accept = mem_we_reg & MemReady;
    assign mem_stall  = mem_we_reg & ~MemReady;
    assign addr_next  = mem_accept ? fb_addr_inc(addr_reg) : addr_reg;

`ifdef SPI_CMD_TIMEOUT_EN
    localparam int TO_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'((TIMEOUT_CYCLES < 1) ? 0 : TIMEOUT_CYCLES - 1);
    logic [TO_W-1:0] idle_cnt_reg;
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES == 0);
`endif

    // Command sequencer: decodes bytes, tracks address/count and drives
    // the registered write strobes.
    always_ff @(posedge Clk) begin
        if (!ResetN) begin
            state_reg     <= S_IDLE;
            addr_reg      <= '0;
            count_reg     <= '0;
            ctrl_idx_reg  <= '0;
            mem_addr_reg  <= '0;
            mem_data_reg  <= '0;
            mem_we_reg    <= 1'b0;
            ctrl_addr_reg <= '0;
            ctrl_data_reg <= '0;
            ctrl_we_reg   <= 1'b0;
            overrun_reg   <= 1'b0;
`ifdef SPI_CMD_TIMEOUT_EN
            idle_cnt_reg  <= '0;
`endif
        end else begin
            ctrl_we_reg <= 1'b0;

            if (mem_accept) begin
                mem_we_reg <= 1'b0;
                addr_reg   <= addr_next;
            end

            if (byte_stb) begin
                case (state_reg)
                    S_IDLE: begin
                        case (cmd_opcode(rx_byte))
                            OP_NOP: begin
                                overrun_reg <= 1'b0;
                            end
                            OP_SET_ADDR: begin
                                addr_reg  <= {rx_byte[5:0], addr_next[7:0]};
                                state_reg <= S_ADDR_LO;
                            end
                            OP_CTRL_WR: begin
                                ctrl_idx_reg <= rx_byte[5:0];
                                state_reg    <= S_CTRL;
                            end
                            OP_BURST: begin
                                count_reg <= rx_byte[5:0];
                                state_reg <= S_DATA;
                            end
                            default: state_reg <= S_IDLE;
                        endcase
                    end
                    S_ADDR_LO: begin
                        addr_reg  <= {addr_next[13:8], rx_byte};
                        state_reg <= S_IDLE;
                    end
                    S_CTRL: begin
                        ctrl_addr_reg <= ctrl_idx_reg;
                        ctrl_data_reg <= rx_byte;
                        ctrl_we_reg   <= 1'b1;
                        state_reg     <= S_IDLE;
                    end
                    S_DATA: begin
                        if (mem_stall) begin
                            overrun_reg <= 1'b1;
                        end else begin
                            mem_addr_reg <= addr_next;
                            mem_data_reg <= rx_byte;
                            mem_we_reg   <= 1'b1;
                        end
                        if (count_reg == '0) begin
                            state_reg <= S_IDLE;
                        end else begin
                            count_reg <= count_reg - 1'b1;
                        end
                    end
                    default: state_reg <= S_IDLE;
                endcase
            end

`ifdef SPI_CMD_TIMEOUT_EN
            if (byte_stb || state_reg == S_IDLE) begin
                idle_cnt_reg <= '0;
            end else if (idle_cnt_reg == TO_LAST) begin
                state_reg    <= S_IDLE;
                count_reg    <= '0;
                idle_cnt_reg <= '0;
            end else begin
                idle_cnt_reg <= idle_cnt_reg + 1'b1;
            end
`endif
        end
    end

    assign MemAddr  = mem_addr_reg;
    assign MemData  = mem_data_reg;
    assign MemWe    = mem_we_reg;
    assign CtrlAddr = ctrl_addr_reg;
    assign CtrlData = ctrl_data_reg;
    assign CtrlWe   = ctrl_we_reg;
    assign Overrun  = overrun_reg;
    assign Busy     = (state_reg != S_IDLE) | mem_we_reg;

endmodule
